// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and default operand width for the serial subtractor
package serial_sub_pkg;
  localparam int DEFAULT_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/full_sub_cell.sv
// full_sub_cell: 1-bit full subtractor built from two half-subtractor stages
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1, b1, b2;
  // first stage subtracts y from x, second stage subtracts the incoming borrow
  always_comb begin
    d1   = x ^ y;
    b1   = ~x & y;
    d    = d1 ^ bin;
    b2   = ~d1 & bin;
    bout = b1 | b2;
  end
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial W-bit unsigned subtractor with valid/ready handshakes
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         borrow,
  output logic         busy
);
  localparam int CW = $clog2(W) + 1;
  state_t         state, state_nxt;
  logic [W-1:0]   a_r, b_r, res_w, res_nxt, bit_mask;
  logic [CW-1:0]  cnt;
  logic           bor, a_bit, b_bit, d, bout, last;
  full_sub_cell u_cell (
    .x   (a_bit),
    .y   (b_bit),
    .bin (bor),
    .d   (d),
    .bout(bout)
  );
  // select the operand bits for the current position and merge the new result bit
  always_comb begin
    bit_mask = W'(1) << cnt;
    a_bit    = |(a_r & bit_mask);
    b_bit    = |(b_r & bit_mask);
    res_nxt  = (res_w & ~bit_mask) | (W'(d) << cnt);
    last     = cnt == CW'(W - 1);
  end
  // state register; reset lands in IDLE so in_ready rises while rst_n is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end
  // next-state and handshake outputs decoded from the state
  always_comb begin
    state_nxt = state;
    in_ready  = state == IDLE;
    busy      = state == RUN;
    out_valid = state == DONE;
    if (state == IDLE && in_valid)       state_nxt = RUN;
    else if (state == RUN && last)       state_nxt = DONE;
    else if (state == DONE && out_ready) state_nxt = IDLE;
  end
  // datapath: latch operands on accept, one bit per RUN edge, publish result on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      res_w  <= '0;
      cnt    <= '0;
      bor    <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_r <= a;
      b_r <= b;
      cnt <= '0;
      bor <= 1'b0;
    end else if (state == RUN) begin
      res_w <= res_nxt;
      bor   <= bout;
      cnt   <= cnt + 1'b1;
      if (last) begin
        diff   <= res_nxt;
        borrow <= bout;
      end
    end
  end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: randomized scoreboard bench for the serial subtractor
module tb_serial_sub_ctrl;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, borrow, busy;
  logic [W-1:0] diff;
  int           checks = 0;
  int           errors = 0;
  logic [W:0]   sbq[$];
  logic [W:0]   last_res = '0;
  logic [W:0]   mon_e;
  bit           ov_q = 1'b0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .borrow   (borrow),
    .busy     (busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [W:0] model(input int x, input int y);
    logic [W:0] r;
    r[W-1:0] = W'((x - y + (1 << W)) % (1 << W));
    r[W]     = x < y;
    return r;
  endfunction

  // monitor: pops the scoreboard each time a new result is presented
  always @(negedge clk) begin
    if (out_valid && !ov_q) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got diff %0d borrow %0d expected none", diff, borrow);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_diff", int'(diff), int'(mon_e[W-1:0]));
        chk("sb_borrow", int'(borrow), int'(mon_e[W]));
      end
    end
    ov_q = out_valid;
  end

  task automatic run_op(input int x, input int y, input int hold, input bit poke);
    int e;
    logic [W:0] ex;
    e = 0;
    while (!in_ready && e < 50) begin
      @(negedge clk);
      e++;
    end
    chk("in_ready_wait", int'(in_ready), 1);
    ex = model(x, y);
    a = W'(x);
    b = W'(y);
    in_valid = 1'b1;
    sbq.push_back(ex);
    @(negedge clk);
    in_valid = 1'b0;
    a = '0;
    b = '0;
    chk("busy_run", int'(busy), 1);
    chk("in_ready_run", int'(in_ready), 0);
    e = 0;
    while (!out_valid && e < 3 * W) begin
      chk("diff_hold_run", int'(diff), int'(last_res[W-1:0]));
      in_valid = poke && e == 2;
      if (in_valid) begin
        a = 1;
        b = 1;
      end
      @(negedge clk);
      e++;
    end
    in_valid = 1'b0;
    chk("latency", e, W);
    for (int i = 0; i < hold; i++) begin
      chk("ov_stall", int'(out_valid), 1);
      chk("in_ready_stall", int'(in_ready), 0);
      chk("busy_stall", int'(busy), 0);
      chk("diff_stall", int'(diff), int'(ex[W-1:0]));
      chk("borrow_stall", int'(borrow), int'(ex[W]));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ov_after", int'(out_valid), 0);
    chk("in_ready_after", int'(in_ready), 1);
    chk("diff_idle", int'(diff), int'(ex[W-1:0]));
    chk("borrow_idle", int'(borrow), int'(ex[W]));
    last_res = ex;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_borrow", int'(borrow), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(200, 55, 0, 1'b0);
    run_op(5, 10, 1, 1'b0);
    run_op(8'h3C, 8'h3C, 0, 1'b0);
    run_op(0, 1, 0, 1'b0);
    run_op(77, 33, 5, 1'b0);
    run_op(100, 30, 0, 1'b1);
    a = 200;
    b = 55;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_diff", int'(diff), 0);
    chk("mid_rst_borrow", int'(borrow), 0);
    sbq.delete();
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(9, 4, 0, 1'b0);
    run_op(255, 0, 0, 1'b0);
    run_op(0, 255, 2, 1'b0);
    run_op(255, 255, 0, 1'b0);
    for (int i = 0; i < 25; i++)
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    repeat (2) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
